spk_chunk_reader: RTL and testbench
===================================

Name: spk_chunk_reader

Overview:
- Read-side counterpart of the chunked input-spike loader.
- Snapshots a 1024-bit spike vector (output-layer or hidden-layer spikes gathered by the array) on a capture strobe.
- Streams the snapshot to the host/bus side as eight 128-bit chunks, each tagged with a 3-bit chunk index, over a valid/ready handshake.
- Chunk index N carries bits [N*128+127 : N*128], the same index-to-slice mapping the loader uses on the write side.

Parameters:
- CHUNK_W, 128, width of one transferred chunk.
- N_CHUNKS, 8, chunks per snapshot; total vector width = CHUNK_W*N_CHUNKS.
- IDX_W, 3, chunk index width; must equal clog2(N_CHUNKS).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- spk_vec_in  input  1024  live spike vector, sampled only on accepted capture.
- capture  input  1  request to snapshot spk_vec_in and start streaming.
- busy  output  1  high while a snapshot is being streamed (state SEND).
- chunk_out  output  128  current chunk data; 0 when chunk_valid is low.
- chunk_idx  output  3  index of the current chunk; 0 when idle.
- chunk_valid  output  1  chunk_out/chunk_idx are valid.
- chunk_ready  input  1  consumer accepts the chunk when chunk_valid && chunk_ready.
- chunk_last  output  1  chunk_valid && the current chunk is the final one of this snapshot.
- done  output  1  one-cycle pulse in the cycle after the final chunk handshake.
- overrun  output  1  sticky; set when capture is ignored because busy; cleared only by reset.

Behaviour:
- Reset:
  - State is IDLE.
  - busy, chunk_valid, chunk_last, done and overrun are 0.
  - chunk_out is 0 and chunk_idx is 0.
  - The shadow register is cleared.
- States: IDLE, SEND.
- IDLE, capture=1:
  - Shadow register <= spk_vec_in; idx <= 0 (first chunk); next state SEND.
  - chunk_valid rises the following cycle, so capture-to-first-valid latency is 1 cycle.
- IDLE, capture=0: no change.
- SEND:
  - chunk_valid=1, chunk_out = shadow[idx*128 +: 128], chunk_idx = idx.
  - Outputs hold stable until the handshake; chunk_ready may be low for any number of cycles.
  - On a handshake with a non-final chunk, idx advances to the next chunk in the following cycle.
  - On a handshake with the final chunk, the next state is IDLE and done pulses for 1 cycle.
- Throughput: one chunk per cycle when chunk_ready is held high, so 8 chunks take 8 cycles.
- capture while in SEND, except in the final-handshake cycle: ignored, overrun <= 1, shadow register untouched.
- capture in the same cycle as the final handshake: accepted back-to-back.
  - New snapshot taken, idx=0, state stays SEND.
  - done still pulses.
  - chunk_valid stays high continuously and chunk_idx goes 7 -> 0.
- spk_vec_in changing during SEND has no effect on the streamed data.
- Reset mid-stream: returns to IDLE next cycle, chunk_valid drops, and the stream is abandoned with no done pulse.

Optional Feature:
- Macro: SPK_RD_SKIP_ZERO_EN.
- Without the macro: all N_CHUNKS chunks are always sent, and chunk_last is asserted on index 7.
- With the macro:
  - At capture, an 8-bit nonzero mask is registered (bit N = |slice N).
  - SEND presents only chunks whose mask bit is set, in ascending index order; idx jumps directly to the next set bit.
  - chunk_last is asserted on the highest set bit.
  - All-zero snapshot: SEND is never entered, chunk_valid stays low, and done pulses in the cycle after capture (busy stays 0).
  - Back-to-back capture on the final handshake follows the same rule: the first chunk shown is the lowest set bit of the new mask.

Decomposition:
- Shared package spk_pkg holds:
  - localparams CHUNK_W, N_CHUNKS, IDX_W, SPK_VEC_W (=1024);
  - the state encoding (IDLE=0, SEND=1);
  - the chunk slice helper function.
- The loader and this block both use the package, so the index-to-slice mapping is defined once.
- One sub-module, spk_chunk_next_sel:
  - Combinational find-next-set-bit on the nonzero mask strictly above idx, plus a has-next flag.
  - Instantiated only under SPK_RD_SKIP_ZERO_EN.

Test Plan:
- Readback order: spk_vec_in = {8 chunks, chunk N = 128'hN repeated}, capture, chunk_ready=1 → chunk_idx 0..7 on 8 consecutive cycles, data matches each slice, chunk_last on idx 7, done 1 cycle later.
- Backpressure: chunk_ready toggles 1,0,0,1 pattern → each chunk held stable until accepted; no index skipped or duplicated; spk_vec_in changed to all-ones mid-stream does not appear in the data.
- Overrun and back-to-back:
  - capture pulsed at chunk 3 → ignored, overrun=1 and stays 1.
  - capture on the idx-7 handshake → chunk_valid stays high, idx 7→0, and the new data is streamed.
- Reset mid-stream: reset at chunk 5 → next cycle chunk_valid=0, chunk_idx=0, overrun=0, no done; a fresh capture then streams from chunk 0.
- Skip-zero (macro on): only slices 2 and 6 nonzero → exactly two transfers (idx 2, then idx 6 with chunk_last).
- Skip-zero (macro on): all-zero vector → no valid, done pulses 1 cycle after capture.

Source files
------------

// File: rtl/spk_pkg.sv
// Shared definitions for the chunked spike loader and reader: sizes, FSM encoding and the
// single definition of the chunk-index-to-slice mapping.
package spk_pkg;

    localparam int unsigned CHUNK_W   = 128;
    localparam int unsigned N_CHUNKS  = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned SPK_VEC_W = CHUNK_W * N_CHUNKS;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } spk_state_e;

    // Chunk N is bits [N*CHUNK_W + CHUNK_W-1 : N*CHUNK_W].
    function automatic logic [CHUNK_W-1:0] chunk_slice(input logic [SPK_VEC_W-1:0] vec,
                                                       input logic [IDX_W-1:0]     idx);
        return vec[idx*CHUNK_W +: CHUNK_W];
    endfunction

    function automatic logic [N_CHUNKS-1:0] nz_mask(input logic [SPK_VEC_W-1:0] vec);
        logic [N_CHUNKS-1:0] m;
        for (int unsigned i = 0; i < N_CHUNKS; i++) begin
            m[i] = |chunk_slice(vec, IDX_W'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/spk_chunk_next_sel.sv
// Finds the lowest set bit of the nonzero-chunk mask strictly above the current index.
module spk_chunk_next_sel
    import spk_pkg::*;
(
    input  logic [N_CHUNKS-1:0] mask,
    input  logic [IDX_W-1:0]    idx,
    output logic [IDX_W-1:0]    next_idx,
    output logic                has_next
);

    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        // Scan downward so the lowest qualifying bit is the last one written.
        for (int i = int'(N_CHUNKS) - 1; i >= 0; i--) begin
            if (i > int'(idx) && mask[i]) begin
                next_idx = IDX_W'(i);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spk_chunk_reader.sv
// Snapshots the spike vector on capture and streams it out as indexed chunks over valid/ready.
// Define SPK_RD_SKIP_ZERO_EN to skip all-zero chunks (and whole all-zero snapshots).
module spk_chunk_reader
    import spk_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SPK_VEC_W-1:0] spk_vec_in,
    input  logic                 capture,
    output logic                 busy,
    output logic [CHUNK_W-1:0]   chunk_out,
    output logic [IDX_W-1:0]     chunk_idx,
    output logic                 chunk_valid,
    input  logic                 chunk_ready,
    output logic                 chunk_last,
    output logic                 done,
    output logic                 overrun
);

    spk_state_e           state;
    logic [SPK_VEC_W-1:0] shadow;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     next_idx;
    logic                 has_next;
    logic                 snap_empty;
    logic                 xfer;

`ifdef SPK_RD_SKIP_ZERO_EN
    logic [N_CHUNKS-1:0] mask;
    logic [N_CHUNKS-1:0] cap_mask;

    assign cap_mask   = nz_mask(spk_vec_in);
    assign snap_empty = ~|cap_mask;

    always_comb begin
        first_idx = '0;
        for (int i = int'(N_CHUNKS) - 1; i >= 0; i--) begin
            if (cap_mask[i]) first_idx = IDX_W'(i);
        end
    end

    // Mask follows the shadow: loaded on every accepted capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (capture && (!busy || (xfer && chunk_last))) begin
            mask <= cap_mask;
        end
    end

    spk_chunk_next_sel u_next_sel (
        .mask     (mask),
        .idx      (chunk_idx),
        .next_idx (next_idx),
        .has_next (has_next)
    );
`else
    assign first_idx  = '0;
    assign snap_empty = 1'b0;
    assign next_idx   = chunk_idx + 1'b1;
    assign has_next   = (chunk_idx != IDX_W'(N_CHUNKS - 1));
`endif

    assign xfer       = chunk_valid & chunk_ready;
    assign chunk_last = chunk_valid & ~has_next;
    assign chunk_out  = chunk_valid ? chunk_slice(shadow, chunk_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            shadow      <= '0;
            chunk_idx   <= '0;
            chunk_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (capture) begin
                        shadow <= spk_vec_in;
                        if (snap_empty) begin
                            done <= 1'b1;
                        end else begin
                            chunk_idx   <= first_idx;
                            chunk_valid <= 1'b1;
                            busy        <= 1'b1;
                            state       <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (xfer && chunk_last) begin
                        done <= 1'b1;
                        if (capture) shadow <= spk_vec_in;
                        if (capture && !snap_empty) begin
                            chunk_idx <= first_idx;
                        end else begin
                            chunk_idx   <= '0;
                            chunk_valid <= 1'b0;
                            busy        <= 1'b0;
                            state       <= StIdle;
                        end
                    end else begin
                        if (xfer) chunk_idx <= next_idx;
                        if (capture) overrun <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spk_chunk_reader.sv
// Bench for spk_chunk_reader: table-driven snapshots checked through a chunk scoreboard,
// plus hand-written overrun, back-to-back and mid-stream reset sequences.
module tb_spk_chunk_reader;
    import spk_pkg::*;

`ifdef SPK_RD_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [SPK_VEC_W-1:0] spk_vec_in;
    logic                 capture;
    logic                 busy;
    logic [CHUNK_W-1:0]   chunk_out;
    logic [IDX_W-1:0]     chunk_idx;
    logic                 chunk_valid;
    logic                 chunk_ready = 1'b0;
    logic                 chunk_last;
    logic                 done;
    logic                 overrun;

    always #5 clk = ~clk;

    spk_chunk_reader dut (
        .clk         (clk),
        .reset       (reset),
        .spk_vec_in  (spk_vec_in),
        .capture     (capture),
        .busy        (busy),
        .chunk_out   (chunk_out),
        .chunk_idx   (chunk_idx),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_last  (chunk_last),
        .done        (done),
        .overrun     (overrun)
    );

    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [CHUNK_W-1:0] data;
        logic               last;
    } exp_t;

    typedef struct {
        logic [SPK_VEC_W-1:0] vec;
        logic [3:0]           rdy;
        int                   exp_xfers;
        int                   exp_first;
    } vec_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         xfers  = 0;
    bit         mon_en = 1'b0;
    logic [3:0] rdy_pat = 4'b1111;
    int         rcnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: expected chunk sequence of one accepted snapshot.
    task automatic push_snapshot(input logic [SPK_VEC_W-1:0] v);
        int           hi;
        logic [127:0] s;
        exp_t         e;
        hi = -1;
        for (int n = 0; n < 8; n++) begin
            s = v[n*128 +: 128];
            if (!SKIP || s != 0) hi = n;
        end
        for (int n = 0; n < 8; n++) begin
            s = v[n*128 +: 128];
            if (!SKIP || s != 0) begin
                e.idx  = 3'(n);
                e.data = s;
                e.last = (n == hi);
                sb.push_back(e);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        chunk_ready = rdy_pat[rcnt % 4];
        rcnt++;
    end

    logic               done_exp = 1'b0;
    logic               hold_prev = 1'b0;
    logic [IDX_W-1:0]   prev_idx;
    logic [CHUNK_W-1:0] prev_data;

    always @(negedge clk) begin
        logic nxt_done;
        exp_t e;
        nxt_done = 1'b0;
        if (mon_en) begin
            chk("done pulse", 128'(done), 128'(done_exp));
            if (!chunk_valid) begin
                chk("idle chunk_out", chunk_out, 128'd0);
                chk("idle chunk_idx", 128'(chunk_idx), 128'd0);
            end
            if (hold_prev) begin
                chk("hold valid", 128'(chunk_valid), 128'd1);
                chk("hold idx", 128'(chunk_idx), 128'(prev_idx));
                chk("hold data", chunk_out, prev_data);
            end
            if (chunk_valid && chunk_ready && !reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected chunk: got idx %0d want none", chunk_idx);
                end else begin
                    e = sb.pop_front();
                    chk("chunk idx", 128'(chunk_idx), 128'(e.idx));
                    chk("chunk data", chunk_out, e.data);
                    chk("chunk last", 128'(chunk_last), 128'(e.last));
                    xfers++;
                    if (e.last) nxt_done = 1'b1;
                end
            end
            if (SKIP && capture && !busy && !reset && spk_vec_in == '0) nxt_done = 1'b1;
        end
        hold_prev = mon_en && chunk_valid && !chunk_ready && !reset;
        prev_idx  = chunk_idx;
        prev_data = chunk_out;
        done_exp  = reset ? 1'b0 : nxt_done;
    end

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (!busy && sb.size() == 0) break;
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL drain timeout: got %0d chunks pending want 0", sb.size());
        end
    endtask

    task automatic wait_idx(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (chunk_valid && chunk_idx == 3'(n)) break;
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL wait idx timeout: got idx %0d want %0d", chunk_idx, n);
        end
    endtask

    function automatic logic [SPK_VEC_W-1:0] rand_vec();
        logic [SPK_VEC_W-1:0] v;
        for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom();
        for (int n = 0; n < 8; n++) v[n*128] = 1'b1;  // every slice nonzero
        return v;
    endfunction

    initial begin
        vec_t                 tbl[4];
        logic [SPK_VEC_W-1:0] va;
        logic [SPK_VEC_W-1:0] vb;

        for (int n = 0; n < 8; n++) tbl[0].vec[n*128 +: 128] = {32{4'(n)}};
        tbl[0].rdy = 4'b1111; tbl[0].exp_xfers = 8; tbl[0].exp_first = 0;
        tbl[1].vec = rand_vec();
        tbl[1].rdy = 4'b1001; tbl[1].exp_xfers = 8; tbl[1].exp_first = 0;
        tbl[2].vec = '0;
        tbl[2].vec[2*128 +: 128] = {4{32'hA5A5_0F0F}};
        tbl[2].vec[6*128 +: 128] = 128'h1;
        tbl[2].rdy = 4'b1111; tbl[2].exp_xfers = SKIP ? 2 : 8; tbl[2].exp_first = SKIP ? 2 : 0;
        tbl[3].vec = '0;
        tbl[3].rdy = 4'b1001; tbl[3].exp_xfers = SKIP ? 0 : 8; tbl[3].exp_first = 0;

        reset      = 1'b1;
        capture    = 1'b0;
        spk_vec_in = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset valid", 128'(chunk_valid), 128'd0);
        chk("reset last", 128'(chunk_last), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset overrun", 128'(overrun), 128'd0);
        chk("reset idx", 128'(chunk_idx), 128'd0);
        chk("reset data", chunk_out, 128'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int t = 0; t < 4; t++) begin
            rdy_pat = tbl[t].rdy;
            xfers   = 0;
            @(posedge clk);
            #2;
            spk_vec_in = tbl[t].vec;
            capture    = 1'b1;
            push_snapshot(tbl[t].vec);
            @(posedge clk);
            #2;
            capture    = 1'b0;
            spk_vec_in = '1;  // must not leak into the stream
            chk("first valid", 128'(chunk_valid), 128'(tbl[t].exp_xfers > 0));
            chk("first busy", 128'(busy), 128'(tbl[t].exp_xfers > 0));
            if (tbl[t].exp_xfers > 0) chk("first idx", 128'(chunk_idx), 128'(tbl[t].exp_first));
            wait_drain(200);
            chk("xfer count", 128'(xfers), 128'(tbl[t].exp_xfers));
            spk_vec_in = '0;
        end
        chk("no overrun yet", 128'(overrun), 128'd0);

        // Ignored capture mid-stream, then back-to-back capture on the final handshake.
        rdy_pat = 4'b1111;
        va = rand_vec();
        vb = rand_vec();
        @(posedge clk);
        #2;
        spk_vec_in = va;
        capture    = 1'b1;
        push_snapshot(va);
        @(posedge clk);
        #2;
        capture = 1'b0;
        wait_idx(3, 50);
        spk_vec_in = vb;
        capture    = 1'b1;
        @(posedge clk);
        #2;
        capture = 1'b0;
        chk("overrun set", 128'(overrun), 128'd1);
        wait_idx(7, 50);
        capture = 1'b1;
        push_snapshot(vb);
        @(posedge clk);
        #2;
        capture    = 1'b0;
        spk_vec_in = '0;
        chk("b2b valid", 128'(chunk_valid), 128'd1);
        chk("b2b idx", 128'(chunk_idx), 128'd0);
        wait_drain(200);
        chk("overrun sticky", 128'(overrun), 128'd1);

        // Reset mid-stream abandons the stream; a fresh capture restarts at chunk 0.
        @(posedge clk);
        #2;
        spk_vec_in = va;
        capture    = 1'b1;
        push_snapshot(va);
        @(posedge clk);
        #2;
        capture = 1'b0;
        wait_idx(5, 50);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        chk("rst valid", 128'(chunk_valid), 128'd0);
        chk("rst idx", 128'(chunk_idx), 128'd0);
        chk("rst overrun", 128'(overrun), 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        @(posedge clk);
        #2;
        spk_vec_in = vb;
        capture    = 1'b1;
        push_snapshot(vb);
        @(posedge clk);
        #2;
        capture = 1'b0;
        chk("restart idx", 128'(chunk_idx), 128'd0);
        chk("restart valid", 128'(chunk_valid), 128'd1);
        wait_drain(200);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
